// File: rtl/and_result_fifo_pkg.sv
// Shared widths and constants for the AND-result FIFO: pointer/level sizing
// derived from the FIFO depth, and the saturation value of the hit counter.
package and_result_fifo_pkg;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  // Level must represent both 0 and DEPTH, hence one bit more than a pointer.
  function automatic int unsigned lvl_w(input int unsigned depth);
    return ptr_w(depth) + 1;
  endfunction

  function automatic longint unsigned cnt_max(input int unsigned cnt_w);
    return (64'd1 << cnt_w) - 64'd1;
  endfunction

endpackage

// File: rtl/sync_fifo_ctrl.sv
// Pointer and occupancy control for a power-of-two synchronous FIFO;
// produces the qualified push/pop strobes and the valid/ready flags.
module sync_fifo_ctrl
  import and_result_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = ptr_w(DEPTH),
  localparam int unsigned LVL_W = lvl_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_req,
  input  logic             rd_req,
  output logic             wr_en,
  output logic             rd_en,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [LVL_W-1:0] level,
  output logic             in_ready,
  output logic             out_valid
);

  assign in_ready  = (level != LVL_W'(DEPTH));
  assign out_valid = (level != '0);
  assign wr_en     = wr_req & in_ready;
  assign rd_en     = rd_req & out_valid;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/and_result_fifo.sv
// Buffers each AB_AND word with its reduction-AND flag and hands them on over
// valid/ready; counts (saturating) accepted words whose flag is 1.
module and_result_fifo
  import and_result_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8,
  localparam int unsigned PTR_W = ptr_w(DEPTH),
  localparam int unsigned LVL_W = lvl_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_and,
  input  logic             out_ready,
  output logic [LVL_W-1:0] level,
  output logic [CNT_W-1:0] hit_cnt
);

  typedef struct packed {
    logic [WIDTH-1:0] word;
    logic             flag;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  logic             push;
  logic             pop;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  entry_t           wr_entry;
  entry_t           head;
  entry_t           mem [DEPTH];

  sync_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .wr_req    (in_valid),
    .rd_req    (out_ready),
    .wr_en     (push),
    .rd_en     (pop),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .level     (level),
    .in_ready  (in_ready),
    .out_valid (out_valid)
  );

  // The flag is fixed at push time so the read side is a plain mux.
  assign wr_entry = '{word: in_data, flag: &in_data};

  // NOTE: storage is deliberately not reset; empty slots are never observed
  // because the head is masked while out_valid is low.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= wr_entry;
  end

  assign head     = mem[rd_ptr];
  assign out_data = out_valid ? head.word : '0;
  assign out_and  = out_valid ? head.flag : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt <= '0;
    end else if (push && wr_entry.flag && hit_cnt != CNT_MAX) begin
      hit_cnt <= hit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_and_result_fifo.sv
// Directed self-checking bench for and_result_fifo (WIDTH=2, DEPTH=4, CNT_W=3).
module tb_and_result_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [1:0] out_data;
  logic       out_and;
  logic       out_ready;
  logic [2:0] level;
  logic [2:0] hit_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  and_result_fifo #(.WIDTH(2), .DEPTH(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_and   (out_and),
    .out_ready (out_ready),
    .level     (level),
    .hit_cnt   (hit_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  logic [1:0] fill_v [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
  logic       fill_a [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 2'b11;
    out_ready = 1'b0;
    #2;

    // 1. reset held two cycles with in_valid asserted
    tick();
    tick();
    check("rst_level", 32'(level), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_hit_cnt", 32'(hit_cnt), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_and", 32'(out_and), 0);
    rst = 1'b0;
    in_valid = 1'b0;

    // 2. single word, held while out_ready=0
    in_valid = 1'b1;
    in_data = 2'b11;
    tick();
    in_valid = 1'b0;
    check("single_valid", 32'(out_valid), 1);
    check("single_data", 32'(out_data), 3);
    check("single_and", 32'(out_and), 1);
    check("single_hit", 32'(hit_cnt), 1);
    check("single_level", 32'(level), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("single_hold_data", 32'(out_data), 3);
      check("single_hold_valid", 32'(out_valid), 1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("single_pop_level", 32'(level), 0);
    check("single_pop_valid", 32'(out_valid), 0);

    // 3. fill to full, overflow push ignored, drain in order
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data = fill_v[i];
      tick();
    end
    check("fill_level", 32'(level), 4);
    check("fill_in_ready", 32'(in_ready), 0);
    in_data = 2'b11;
    tick();
    in_valid = 1'b0;
    check("fill_over_level", 32'(level), 4);
    check("fill_over_hit", 32'(hit_cnt), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_data", 32'(out_data), 32'(fill_v[i]));
      check("drain_and", 32'(out_and), 32'(fill_a[i]));
      tick();
    end
    out_ready = 1'b0;
    check("drain_level", 32'(level), 0);
    check("drain_hit", 32'(hit_cnt), 1);

    // 4. streaming push+pop for 20 cycles, pointers wrap several times
    do_reset();
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 2'(i % 4);
      if (i > 0) begin
        check("stream_valid", 32'(out_valid), 1);
        check("stream_data", 32'(out_data), 32'((i - 1) % 4));
      end
      tick();
      check("stream_level", 32'(level), 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("stream_hit", 32'(hit_cnt), 5);
    check("stream_last", 32'(out_data), 3);

    // 5. full, then simultaneous push+pop requests
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data = 2'(i);
      tick();
    end
    check("full_level", 32'(level), 4);
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_data = 2'b11;
    tick();
    check("full_pop_level", 32'(level), 3);
    check("full_pop_hit", 32'(hit_cnt), 1);
    check("full_pop_head", 32'(out_data), 1);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("pushpop_level", 32'(level), 3);
    check("pushpop_hit", 32'(hit_cnt), 2);
    check("pushpop_head", 32'(out_data), 2);

    // 6. counter saturation, then reset mid-run
    do_reset();
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_data = 2'b11;
    for (int i = 0; i < 10; i++) tick();
    check("sat_hit", 32'(hit_cnt), 7);
    check("sat_level", 32'(level), 1);
    out_ready = 1'b0;
    tick();
    check("sat_hold_hit", 32'(hit_cnt), 7);
    check("sat_level2", 32'(level), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check("midrst_level", 32'(level), 0);
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_ready", 32'(in_ready), 1);
    check("midrst_hit", 32'(hit_cnt), 0);
    check("midrst_data", 32'(out_data), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
